// File: rtl/packet_rr_arbiter.sv
// Packet-granular round-robin arbiter: N_REQ valid/ready requesters share one
// downstream channel, with an optional beat-count watchdog per grant.
module packet_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_valid,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_last,
    input  logic                    i_ready,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_busy,
    output logic                    o_err
);

    localparam int IDX_W = $clog2(N_REQ);
    // A zero-width counter is illegal, so a disabled watchdog keeps one unused bit.
    localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);
    localparam logic [N_REQ-1:0] GRANT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [CNT_W-1:0] beat_cnt;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic             sel_valid;
    logic             sel_last;
    logic [DATA_W-1:0] sel_data;
    logic             locked;
    logic             xfer;
    logic             wd_hit;
    logic [IDX_W-1:0] next_ptr;

    // Round-robin search starting at ptr; the first set request wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!pick_found && i_req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                sel_valid = i_req_valid[k];
                sel_last  = i_req_last[k];
                sel_data  = i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign locked   = (state == LOCKED);
    assign xfer     = o_valid && i_ready;
    assign wd_hit   = (MAX_BEATS > 0) && (beat_cnt == WD_LAST);
    assign next_ptr = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Pass-through channel; o_grant is one-hot on the granted index while locked.
    assign o_valid     = locked && sel_valid;
    assign o_data      = locked ? sel_data : '0;
    assign o_last      = locked && (sel_last || wd_hit);
    assign o_req_ready = (locked && i_ready) ? o_grant : '0;
    assign o_busy      = locked;

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            o_grant  <= '0;
            beat_cnt <= '0;
            o_err    <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= LOCKED;
                        gnt_idx  <= pick_idx;
                        o_grant  <= GRANT_ONE << pick_idx;
                        beat_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        if (sel_last || wd_hit) begin
                            state    <= IDLE;
                            o_grant  <= '0;
                            beat_cnt <= '0;
                            ptr      <= next_ptr;
                            o_err    <= wd_hit && !sel_last;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Self-checking bench for packet_rr_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_packet_rr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic                    ready;

    logic [N_REQ-1:0]  req_ready, grant;
    logic              valid, last, busy, err;
    logic [DATA_W-1:0] data;

    logic [N_REQ-1:0]  req_ready0, grant0;
    logic              valid0, last0, busy0, err0;
    logic [DATA_W-1:0] data0;

    packet_rr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(req_ready), .o_valid(valid), .o_data(data),
        .o_last(last), .i_ready(ready), .o_grant(grant), .o_busy(busy), .o_err(err)
    );

    // Watchdog-disabled instance sharing the same stimulus.
    packet_rr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BEATS(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(req_ready0), .o_valid(valid0), .o_data(data0),
        .o_last(last0), .i_ready(ready), .o_grant(grant0), .o_busy(busy0), .o_err(err0)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the channel, how many beats they have sent,
    // and whose turn comes next.
    bit m_busy;
    int m_g;
    int m_ptr;
    int m_cnt;
    bit m_err;

    function automatic void model_edge();
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_g = 0;
            return;
        end
        m_err = 0;
        if (!m_busy) begin
            for (int i = 0; i < N_REQ; i++) begin
                int c;
                c = (m_ptr + i) % N_REQ;
                if (req_valid[c]) begin
                    m_busy = 1; m_g = c; m_cnt = 0;
                    break;
                end
            end
        end else if (req_valid[m_g] && ready) begin
            m_cnt++;
            if (req_last[m_g] || (MAX_BEATS > 0 && m_cnt == MAX_BEATS)) begin
                m_err  = !req_last[m_g];
                m_busy = 0;
                m_ptr  = (m_g + 1) % N_REQ;
                m_cnt  = 0;
            end
        end
    endfunction

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; req_last = '0; req_data = $urandom; ready = 1'b1;
        tick();
        tick();
        settle();
        checks++;
        if ({grant, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_state: grant=%b busy=%b err=%b, want all 0", grant, busy, err);
        end
        checks++;
        if ({valid, req_ready, data, last} !== '0) begin
            errors++;
            $display("FAIL reset_channel: valid=%b ready=%b data=%h last=%b, want all 0",
                     valid, req_ready, data, last);
        end
        rst = 1'b0; req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        ready = 1'b1; req_valid = 4'b0010; req_data[1*DATA_W +: DATA_W] = 8'hA5;
        settle();
        checks++;
        if (grant !== 4'b0000 || valid !== 1'b0) begin
            errors++; $display("FAIL single_bubble: grant=%b valid=%b, want 0000/0", grant, valid);
        end
        tick();
        settle();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", grant); end
        checks++;
        if (data !== 8'hA5 || req_ready !== 4'b0010 || last !== 1'b0) begin
            errors++;
            $display("FAIL single_beat1: data=%h ready=%b last=%b, want a5/0010/0", data, req_ready, last);
        end
        tick();
        req_data[1*DATA_W +: DATA_W] = 8'h3C; req_last = 4'b0010;
        settle();
        checks++;
        if (data !== 8'h3C || last !== 1'b1 || valid !== 1'b1) begin
            errors++; $display("FAIL single_beat2: data=%h last=%b valid=%b, want 3c/1/1", data, last, valid);
        end
        tick();
        req_valid = '0; req_last = '0;
        settle();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL single_release: grant=%b busy=%b, want 0000/0", grant, busy);
        end
        // ptr should now be 2: with 0,1,2 requesting, 2 must win.
        req_valid = 4'b0111; req_last = 4'b0111;
        tick();
        settle();
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("FAIL single_ptr: got %b want 0100", grant); end
        tick();
        req_valid = '0; req_last = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [N_REQ-1:0] want;
        do_reset();
        req_valid = 4'b1111; req_last = 4'b1111; ready = 1'b1; req_data = $urandom;
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++;
            if (busy !== 1'b0 || grant !== 4'b0000) begin
                errors++; $display("FAIL fair_bubble%0d: busy=%b grant=%b, want 0/0000", k, busy, grant);
            end
            tick();
            settle();
            want = 4'b0001 << (k % N_REQ);
            checks++;
            if (grant !== want || valid !== 1'b1) begin
                errors++; $display("FAIL fair_grant%0d: grant=%b valid=%b, want %b/1", k, grant, valid, want);
            end
            tick();
        end
        req_valid = '0; req_last = '0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        ready = 1'b1; req_valid = 4'b0100; req_last = 4'b0100;
        tick();
        tick();
        req_valid = 4'b0101; req_last = 4'b0101;
        settle();
        tick();
        settle();
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b want 0001", grant); end
        tick();
        settle();
        tick();
        settle();
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("FAIL wrap_ptr: got %b want 0100", grant); end
        tick();
        req_valid = '0; req_last = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b1000; req_last = '0; ready = 1'b0; req_data[3*DATA_W +: DATA_W] = 8'h5A;
        tick();
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (req_ready !== 4'b0000 || valid !== 1'b1 || data !== 8'h5A || grant !== 4'b1000) begin
                errors++;
                $display("FAIL bp_hold%0d: ready=%b valid=%b data=%h grant=%b, want 0000/1/5a/1000",
                         c, req_ready, valid, data, grant);
            end
            tick();
        end
        ready = 1'b1; req_last = 4'b1000;
        settle();
        checks++;
        if (req_ready !== 4'b1000 || last !== 1'b1) begin
            errors++; $display("FAIL bp_release: ready=%b last=%b, want 1000/1", req_ready, last);
        end
        tick();
        req_valid = '0; req_last = '0;
        settle();
        checks++;
        if (grant !== 4'b0000 || err !== 1'b0) begin
            errors++; $display("FAIL bp_done: grant=%b err=%b, want 0000/0", grant, err);
        end
        tick();
    endtask

    task automatic test_watchdog();
        int  beats;
        int  cyc;
        bit  xfer;
        logic [DATA_W-1:0] d;
        do_reset();
        req_valid = 4'b0001; req_last = '0; ready = 1'b1;
        tick();
        beats = 0;
        cyc = 0;
        while (beats < MAX_BEATS && cyc < 400) begin
            ready = ($urandom % 4) != 0;
            req_valid[0] = ($urandom % 5) != 0;
            d = DATA_W'($urandom);
            req_data[0 +: DATA_W] = d;
            settle();
            checks++;
            if (last !== (beats == MAX_BEATS - 1) || data !== d) begin
                errors++;
                $display("FAIL wd_beat%0d: last=%b data=%h, want %b/%h", beats, last, data,
                         beats == MAX_BEATS - 1, d);
            end
            checks++;
            if (busy0 !== 1'b1 || last0 !== 1'b0) begin
                errors++; $display("FAIL wd_off_beat%0d: busy=%b last=%b, want 1/0", beats, busy0, last0);
            end
            xfer = req_valid[0] && ready;
            tick();
            if (xfer) beats++;
            cyc++;
        end
        checks++;
        if (beats != MAX_BEATS) begin
            errors++; $display("FAIL wd_budget: beats=%0d want %0d", beats, MAX_BEATS);
        end
        req_valid = '0; ready = 1'b1;
        settle();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL wd_release: grant=%b busy=%b err=%b, want 0000/0/1", grant, busy, err);
        end
        checks++;
        if (busy0 !== 1'b1 || err0 !== 1'b0) begin
            errors++; $display("FAIL wd_off_hold: busy=%b err=%b, want 1/0", busy0, err0);
        end
        tick();
        settle();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL wd_err_pulse: err=%b want 0", err); end
        req_valid = 4'b0011; req_last = 4'b0011;
        tick();
        settle();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL wd_ptr: got %b want 0010", grant); end
        tick();
        req_valid = '0; req_last = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0100; req_last = '0; ready = 1'b1; req_data = $urandom;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        settle();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || err !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: grant=%b busy=%b err=%b valid=%b, want 0000/0/0/0",
                     grant, busy, err, valid);
        end
        rst = 1'b0; req_valid = 4'b0110; req_last = 4'b0110;
        tick();
        settle();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL rstmid_ptr: got %b want 0010", grant); end
        tick();
        req_valid = '0; req_last = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N_REQ-1:0]  one = 1;
        logic [N_REQ-1:0]  e_grant, e_ready;
        logic              e_valid, e_last;
        logic [DATA_W-1:0] e_data;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom % 256) == 0;
            req_valid = N_REQ'($urandom);
            req_last  = N_REQ'($urandom & $urandom);
            req_data  = $urandom;
            ready     = ($urandom % 4) != 0;
            settle();
            e_grant = m_busy ? one << m_g : '0;
            e_ready = (m_busy && ready) ? one << m_g : '0;
            e_valid = m_busy && req_valid[m_g];
            e_data  = m_busy ? req_data[m_g*DATA_W +: DATA_W] : '0;
            e_last  = m_busy && (req_last[m_g] || m_cnt == MAX_BEATS - 1);
            checks++;
            if (grant !== e_grant || busy !== m_busy || err !== m_err) begin
                errors++;
                $display("FAIL rand_state@%0d: grant=%b busy=%b err=%b, want %b/%b/%b",
                         n, grant, busy, err, e_grant, m_busy, m_err);
            end
            checks++;
            if (req_ready !== e_ready || valid !== e_valid || data !== e_data || last !== e_last) begin
                errors++;
                $display("FAIL rand_chan@%0d: ready=%b valid=%b data=%h last=%b, want %b/%b/%h/%b",
                         n, req_ready, valid, data, last, e_ready, e_valid, e_data, e_last);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; ready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
